pwm_bit_decoder: RTL

- Sits directly downstream of the 3-sample hysteresis line filter and consumes its filtered level output.
- Measures each high pulse of the filtered line and classifies it: short pulse = bit 0, long pulse = bit 1, anything else = error.
- Assembles NBITS bits, MSB first, into a word and presents it on a valid/ready output with a single holding register.
- A low period of GAP cycles ends the frame and discards any partial word.

---
 rtl/pwm_bit_decoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pwm_bit_decoder.sv
// PWM bit decoder: classifies filtered high-pulse widths into bits,
// packs NBITS bits MSB first and offers each word on a valid/ready port.
module pwm_bit_decoder #(
   parameter int CW        = 8,
   parameter int NBITS     = 8,
   parameter int SHORT_MIN = 3,
   parameter int SHORT_MAX = 5,
   parameter int LONG_MIN  = 6,
   parameter int LONG_MAX  = 12,
   parameter int GAP       = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lvl,
   output logic [NBITS-1:0] data,
   output logic             valid,
   input  logic             ready,
   output logic             frame_end,
   output logic             err,
   output logic             ovf
);

   localparam int BW = $clog2(NBITS + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;
   localparam logic [1:0] ST_SYNC = 2'd3;

   localparam logic [CW-1:0] L_SMIN = CW'(SHORT_MIN);
   localparam logic [CW-1:0] L_SMAX = CW'(SHORT_MAX);
   localparam logic [CW-1:0] L_LMIN = CW'(LONG_MIN);
   localparam logic [CW-1:0] L_LMAX = CW'(LONG_MAX);
   localparam logic [CW-1:0] L_GAP  = CW'(GAP);
   localparam logic [CW-1:0] L_ONE  = CW'(1);
   localparam logic [BW-1:0] L_LAST = BW'(NBITS - 1);

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [BW-1:0]    r_bitcnt;
   logic [NBITS-2:0] r_shift;
   logic [NBITS-1:0] r_data;
   logic             r_valid;
   logic             r_frame_end;
   logic             r_err;
   logic             r_ovf;

   logic [CW-1:0]    w_cnt_inc;
   logic             w_is_short;
   logic             w_is_long;
   logic             w_fall;
   logic             w_good;
   logic             w_stuck;
   logic             w_commit;
   logic [NBITS-1:0] w_word;

   always_comb begin
      w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + L_ONE;
      w_is_short = (r_cnt >= L_SMIN) && (r_cnt <= L_SMAX);
      w_is_long  = (r_cnt >= L_LMIN) && (r_cnt <= L_LMAX);
      w_fall     = (r_state == ST_HIGH) && !lvl;
      w_good     = w_fall && (w_is_short || w_is_long);
      w_stuck    = (r_state == ST_HIGH) && lvl && (w_cnt_inc > L_LMAX);
      w_commit   = w_good && (r_bitcnt == L_LAST);
      w_word     = {r_shift, w_is_long};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_end <= 1'b0;
         r_err       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_frame_end <= 1'b0;
         r_err       <= 1'b0;
         r_ovf       <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (lvl) begin
                  r_state <= ST_HIGH;
                  r_cnt   <= L_ONE;
               end
            end
            ST_HIGH: begin
               if (w_stuck) begin
                  r_err    <= 1'b1;
                  r_bitcnt <= '0;
                  r_cnt    <= '0;
                  r_state  <= ST_SYNC;
               end else if (lvl) begin
                  r_cnt <= w_cnt_inc;
               end else if (w_good) begin
                  r_shift  <= w_word[NBITS-2:0];
                  r_bitcnt <= w_commit ? '0 : r_bitcnt + 1'b1;
                  r_cnt    <= L_ONE;
                  r_state  <= ST_LOW;
               end else begin
                  // the falling sample already counts as the first low
                  r_err    <= 1'b1;
                  r_bitcnt <= '0;
                  r_cnt    <= L_ONE;
                  r_state  <= ST_SYNC;
               end
            end
            ST_LOW: begin
               if (lvl) begin
                  r_cnt   <= L_ONE;
                  r_state <= ST_HIGH;
               end else if (w_cnt_inc == L_GAP) begin
                  r_frame_end <= 1'b1;
                  r_bitcnt    <= '0;
                  r_shift     <= '0;
                  r_cnt       <= '0;
                  r_state     <= ST_IDLE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               if (lvl) begin
                  r_cnt <= '0;
               end else if (w_cnt_inc == L_GAP) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
         endcase

         if (w_commit) begin
            if (!r_valid || ready) begin
               r_data  <= w_word;
               r_valid <= 1'b1;
            end else begin
               r_ovf <= 1'b1;
            end
         end else if (r_valid && ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data      = r_data;
   assign valid     = r_valid;
   assign frame_end = r_frame_end;
   assign err       = r_err;
   assign ovf       = r_ovf;

endmodule
